csr_interrupt_controller: RTL and testbench
===========================================

Name: csr_interrupt_controller

Overview:
Parametrised platform-level interrupt controller. It takes NUM_SOURCES asynchronous device interrupt lines and applies per-source priority, enable, a global threshold, and level or edge gateways. Its single external_interrupt output drives the core CSR unit's pad_external_interrupt. Software reads a claim register to get the winning source ID and writes that ID back to signal completion.

Parameters:
NUM_SOURCES, 8, number of interrupt sources, 1..31; source IDs are 1..NUM_SOURCES and ID 0 means "none".
PRIORITY_WIDTH, 3, bits per source priority and per threshold.
EDGE_MASK, 32'h0, bit i=1 makes source i edge-triggered, 0 makes it level-triggered; bit 0 is ignored.

Ports:
clock  in  1  system clock, all state on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
source_irq  in  NUM_SOURCES+1  device interrupt lines, asynchronous; bit 0 is unused.
bus_read  in  1  single-cycle read strobe.
bus_write  in  1  single-cycle write strobe.
bus_address  in  8  byte address; bits [1:0] are ignored.
bus_write_data  in  32  write data.
bus_read_data  out  32  registered read data.
bus_read_valid  out  1  high for exactly one cycle, the cycle after bus_read.
external_interrupt  out  1  registered request to the hart.

Behaviour:
- Reset: reset_n low clears, immediately and asynchronously, all of the following to 0: synchronisers, pending, in_service, enables, priorities, threshold, bus_read_data, bus_read_valid, external_interrupt. Deasserting reset_n mid-claim loses all in-service state.
- Register map (word addresses):
  - 0x04*i, i=1..NUM_SOURCES: priority[i], RW, only the low PRIORITY_WIDTH bits are stored.
  - 0x00: reads 0, writes ignored.
  - 0x80: pending vector, RO.
  - 0x84: enable vector, RW; bit 0 is forced 0.
  - 0x88: threshold, RW.
  - 0x8C: claim/complete.
  - Any unmapped address reads 0 and ignores writes.
- Synchroniser: each source passes through 2 flops.
  - Level source: an input high sampled at edge k sets pending at edge k+2, provided the gateway is open.
  - Edge source: a rising edge on the synchronised signal sets pending at edge k+2.
  - external_interrupt asserts at edge k+3, provided the source is enabled and its priority exceeds the threshold.
- Eligibility: source i is eligible when pending[i] & enable[i] & (priority[i] > threshold). Priority 0 is never eligible.
- Arbitration: the highest-priority eligible source wins; ties go to the lowest ID.
- external_interrupt: registered OR of eligibility across all sources.
- Claim: bus_read at 0x8C.
  - bus_read_data = winning ID on the next cycle.
  - At the same edge, pending[ID] clears and in_service[ID] sets.
  - With no eligible source: returns 0 and no state changes.
- Gateway:
  - Level source: pending cannot set while in_service is 1.
  - Edge source: new edges are allowed to re-set pending while the source is in service.
  - Edges arriving while pending is already 1 merge into it; there is no count.
- Complete: bus_write at 0x8C with data[4:0]=ID.
  - Clears in_service[ID].
  - Ignored when ID=0, ID>NUM_SOURCES, or in_service[ID]=0.
  - A level source still high re-pends 1 cycle later.
- Simultaneous events:
  - Claim clear and edge set on the same source in the same cycle: set wins, pending stays 1.
  - bus_read and bus_write in the same cycle: both execute; the read returns the pre-write value; the claim is computed from pre-write state.
- Writes to enable, threshold or priority are reflected in external_interrupt at the following edge (one-cycle registered path).
- bus_read_data holds its last value when bus_read_valid is low.

Test Plan:
- Reset: hold reset_n low mid-operation, with source 3 pending -> all outputs 0 asynchronously; after release, pending=0 and claim returns 0.
- Level source 2 (priority 1, enabled, threshold 0), line raised -> pending bit 2 at +2 edges, external_interrupt at +3; claim returns 2 and external_interrupt drops; line still high -> no re-pend until complete(2) is written, then pending reappears 1 cycle later.
- Sources 1, 4, 5 pending with priorities 2, 5, 5 -> claims return 4, then 5, then 1, then 0.
- Threshold 5 with source 4 at priority 5 -> external_interrupt=0; write threshold 4 -> external_interrupt=1 one edge later.
- Edge source 6 (EDGE_MASK bit 6=1): pulse, claim, pulse again before complete -> pending re-sets; a pulse coinciding with the claim edge leaves pending=1.
- Complete with ID 0, ID 9 (NUM_SOURCES=8), and a non-in-service ID -> no state change; read of 0x90 -> 0.

Source files
------------

// File: rtl/csr_interrupt_controller.sv
// Platform-level interrupt controller for a single hart.
// Each source line is synchronised and passed through a level or edge
// gateway into a pending bit. Enable, priority and a global threshold
// decide which pending sources are eligible. The highest priority wins,
// and the lowest ID breaks ties. Software claims the winner through
// register 0x8C and completes it by writing the ID back.
//
// Bus handshake: bus_read and bus_write are single-cycle strobes with no
// back-pressure. bus_read_valid pulses high exactly one cycle after
// bus_read, and bus_read_data carries the registered response. Outside
// that pulse, bus_read_data holds its last value.
module csr_interrupt_controller #(
   parameter int          NUM_SOURCES    = 8,
   parameter int          PRIORITY_WIDTH = 3,
   parameter logic [31:0] EDGE_MASK      = 32'h0
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NUM_SOURCES:0]   source_irq,
   input  logic                   bus_read,
   input  logic                   bus_write,
   input  logic [7:0]             bus_address,
   input  logic [31:0]            bus_write_data,
   output logic [31:0]            bus_read_data,
   output logic                   bus_read_valid,
   output logic                   external_interrupt
);

   localparam logic [5:0] WORD_PENDING   = 6'd32;
   localparam logic [5:0] WORD_ENABLE    = 6'd33;
   localparam logic [5:0] WORD_THRESHOLD = 6'd34;
   localparam logic [5:0] WORD_CLAIM     = 6'd35;

   // Bit 0 is never a real source, so it is never edge-triggered.
   localparam logic [NUM_SOURCES:0] EDGE_SRC = {EDGE_MASK[NUM_SOURCES:1], 1'b0};

   logic [NUM_SOURCES:0]      sync1, sync2, sync_prev;
   logic [NUM_SOURCES:0]      pending, in_service, enable;
   logic [PRIORITY_WIDTH-1:0] prio [1:NUM_SOURCES];
   logic [PRIORITY_WIDTH-1:0] threshold;

   logic [5:0]                word;
   logic [NUM_SOURCES:0]      eligible;
   logic [4:0]                win_id;
   logic [PRIORITY_WIDTH-1:0] win_prio;
   logic                      claim_en, complete_en;
   logic [NUM_SOURCES:0]      claim_vec, complete_vec, pending_set;
   logic [31:0]               read_mux;
   logic                      unused_sink;

   assign word        = bus_address[7:2];
   assign claim_en    = bus_read  && (word == WORD_CLAIM);
   assign complete_en = bus_write && (word == WORD_CLAIM);
   assign unused_sink = ^{bus_address[1:0], source_irq[0], bus_write_data,
                          sync2[0], sync_prev[0], in_service[0]};

   // Eligibility and arbitration: the ascending scan with a strict compare keeps the lowest ID on ties.
   always_comb begin
      eligible = '0;
      win_id   = '0;
      win_prio = '0;
      for (int i = 1; i <= NUM_SOURCES; i++) begin
         if (pending[i] && enable[i] && (prio[i] > threshold)) begin
            eligible[i] = 1'b1;
            if (prio[i] > win_prio) begin
               win_prio = prio[i];
               win_id   = 5'(i);
            end
         end
      end
   end

   // Claim/complete decode and gateway set conditions.
   // A claim suppresses a level re-set at the same edge; an edge set overrides the claim clear.
   always_comb begin
      claim_vec    = '0;
      complete_vec = '0;
      pending_set  = '0;
      for (int i = 1; i <= NUM_SOURCES; i++) begin
         claim_vec[i]    = claim_en && (win_id == 5'(i));
         complete_vec[i] = complete_en && (bus_write_data[4:0] == 5'(i)) && in_service[i];
         if (EDGE_SRC[i])
            pending_set[i] = sync2[i] & ~sync_prev[i];
         else
            pending_set[i] = sync2[i] & ~in_service[i] & ~claim_vec[i];
      end
   end

   // Read data mux, evaluated on pre-write state.
   always_comb begin
      read_mux = '0;
      case (word)
         WORD_PENDING:   read_mux = 32'(pending);
         WORD_ENABLE:    read_mux = 32'(enable);
         WORD_THRESHOLD: read_mux = 32'(threshold);
         WORD_CLAIM:     read_mux = 32'(win_id);
         default: begin
            for (int i = 1; i <= NUM_SOURCES; i++)
               if (word == 6'(i)) read_mux = 32'(prio[i]);
         end
      endcase
   end

   // Two-flop synchroniser plus a delayed copy for rising-edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1     <= '0;
         sync2     <= '0;
         sync_prev <= '0;
      end else begin
         sync1     <= {source_irq[NUM_SOURCES:1], 1'b0};
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   // Software-writable configuration: priorities, enable vector and threshold.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i <= NUM_SOURCES; i++) prio[i] <= '0;
         enable    <= '0;
         threshold <= '0;
      end else if (bus_write) begin
         for (int i = 1; i <= NUM_SOURCES; i++)
            if (word == 6'(i)) prio[i] <= bus_write_data[PRIORITY_WIDTH-1:0];
         if (word == WORD_ENABLE)    enable    <= {bus_write_data[NUM_SOURCES:1], 1'b0};
         if (word == WORD_THRESHOLD) threshold <= bus_write_data[PRIORITY_WIDTH-1:0];
      end
   end

   // Pending and in-service tracking; a same-cycle claim takes precedence over a complete.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending    <= '0;
         in_service <= '0;
      end else begin
         pending    <= pending_set | (pending & ~claim_vec);
         in_service <= (in_service & ~complete_vec) | claim_vec;
      end
   end

   // Registered read response and interrupt request.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus_read_data      <= '0;
         bus_read_valid     <= 1'b0;
         external_interrupt <= 1'b0;
      end else begin
         bus_read_valid     <= bus_read;
         if (bus_read) bus_read_data <= read_mux;
         external_interrupt <= |eligible;
      end
   end

endmodule

// File: tb/tb_csr_interrupt_controller.sv
// Bench for csr_interrupt_controller.
// Directed scenarios are followed by a randomised phase. A behavioural
// model predicts every read response and the interrupt line.
module tb_csr_interrupt_controller;

   localparam int          N       = 8;
   localparam int          PW      = 3;
   localparam logic [31:0] EDGE    = 32'h0000_0040;
   localparam logic [31:0] EN_MASK = 32'h0000_01FE;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [N:0]    source_irq = '0;
   logic          bus_read = 1'b0;
   logic          bus_write = 1'b0;
   logic [7:0]    bus_address = '0;
   logic [31:0]   bus_write_data = '0;
   logic [31:0]   bus_read_data;
   logic          bus_read_valid;
   logic          external_interrupt;

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   int          dir_q[$];

   // model state
   bit [31:0] m_pend = '0, m_ins = '0, m_en = '0;
   bit [31:0] h1 = '0, h2 = '0, h3 = '0;
   int        m_prio[32];
   int        m_thr = 0;
   bit        exp_ext = 1'b0;

   logic [31:0] mon_e;
   int          mon_d;

   csr_interrupt_controller #(
      .NUM_SOURCES(N), .PRIORITY_WIDTH(PW), .EDGE_MASK(EDGE)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .source_irq(source_irq),
      .bus_read(bus_read),
      .bus_write(bus_write),
      .bus_address(bus_address),
      .bus_write_data(bus_write_data),
      .bus_read_data(bus_read_data),
      .bus_read_valid(bus_read_valid),
      .external_interrupt(external_interrupt)
   );

   // clock
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit [31:0] m_elig();
      bit [31:0] e;
      e = '0;
      for (int i = 1; i <= N; i++)
         if (m_pend[i] && m_en[i] && (m_prio[i] > m_thr)) e[i] = 1'b1;
      return e;
   endfunction

   function automatic int m_winner();
      bit [31:0] e;
      int best;
      int bp;
      e = m_elig();
      best = 0;
      bp = 0;
      for (int i = 1; i <= N; i++)
         if (e[i] && (m_prio[i] > bp)) begin
            bp = m_prio[i];
            best = i;
         end
      return best;
   endfunction

   function automatic logic [31:0] m_read(input int w, input int win);
      if (w >= 1 && w <= N) return 32'(m_prio[w]);
      if (w == 32) return m_pend;
      if (w == 33) return m_en;
      if (w == 34) return 32'(m_thr);
      if (w == 35) return 32'(win);
      return 32'h0;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_ins = '0; m_en = '0; m_thr = 0;
      h1 = '0; h2 = '0; h3 = '0;
      for (int i = 0; i < 32; i++) m_prio[i] = 0;
      exp_ext = 1'b0;
   endtask

   task automatic model_step();
      bit [31:0] elig;
      bit [31:0] ins0;
      int win;
      int w;
      int cid;
      bit claimed;
      bit cvalid;
      bit took;
      elig = m_elig();
      win  = m_winner();
      ins0 = m_ins;
      w    = int'(bus_address[7:2]);
      exp_ext = (elig != 0);
      if (bus_read) exp_q.push_back(m_read(w, win));
      claimed = bus_read && (w == 35) && (win != 0);
      cid = int'(bus_write_data[4:0]);
      cvalid = 1'b0;
      if (bus_write) begin
         if (w >= 1 && w <= N) m_prio[w] = int'(bus_write_data[PW-1:0]);
         else if (w == 33) m_en = bus_write_data & EN_MASK;
         else if (w == 34) m_thr = int'(bus_write_data[PW-1:0]);
         else if (w == 35) cvalid = (cid >= 1) && (cid <= N) && ins0[cid];
      end
      for (int i = 1; i <= N; i++) begin
         took = claimed && (i == win);
         if (took) m_pend[i] = 1'b0;
         if (EDGE[i]) begin
            if (h2[i] && !h3[i]) m_pend[i] = 1'b1;
         end else if (h2[i] && !ins0[i] && !took) begin
            m_pend[i] = 1'b1;
         end
      end
      if (cvalid) m_ins[cid] = 1'b0;
      if (claimed) m_ins[win] = 1'b1;
      h3 = h2;
      h2 = h1;
      h1 = 32'(source_irq) & EN_MASK;
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) model_reset();
      else model_step();
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      if (reset_n) begin
         check("ext_irq", {31'b0, external_interrupt}, {31'b0, exp_ext});
         if (bus_read_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid got=1 want=0 at %0t", $time);
            end else begin
               mon_e = exp_q.pop_front();
               mon_d = (dir_q.size() > 0) ? dir_q.pop_front() : -1;
               check("read_data", bus_read_data, mon_e);
               if (mon_d >= 0) check("read_plan", bus_read_data, 32'(mon_d));
            end
         end else if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL missing_valid got=0 want=1 at %0t", $time);
            mon_e = exp_q.pop_front();
            if (dir_q.size() > 0) mon_d = dir_q.pop_front();
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic bus_rd(input logic [7:0] a, input int want);
      bus_read = 1'b1;
      bus_address = a;
      dir_q.push_back(want);
      tick();
      bus_read = 1'b0;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      bus_write = 1'b1;
      bus_address = a;
      bus_write_data = d;
      tick();
      bus_write = 1'b0;
   endtask

   task automatic bus_rdwr(input logic [7:0] a, input logic [31:0] d, input int want);
      bus_read = 1'b1;
      bus_write = 1'b1;
      bus_address = a;
      bus_write_data = d;
      dir_q.push_back(want);
      tick();
      bus_read = 1'b0;
      bus_write = 1'b0;
   endtask

   function automatic logic [7:0] rand_addr();
      int w;
      int lo;
      w = int'($urandom_range(0, 40));
      lo = int'($urandom_range(0, 3));
      return 8'((w * 4) + lo);
   endfunction

   // watchdog
   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog got=timeout want=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int s;
      int op;
      repeat (3) @(posedge clock);
      #1;
      check("reset_rdata", bus_read_data, 32'h0);
      check("reset_valid", {31'b0, bus_read_valid}, 32'h0);
      check("reset_ext", {31'b0, external_interrupt}, 32'h0);
      #1 reset_n = 1'b1;

      bus_rd(8'h80, 0);
      bus_rd(8'h8C, 0);

      // register map
      bus_wr(8'h1C, 32'hFF);
      bus_rd(8'h1C, 7);
      bus_rd(8'h1E, 7);
      bus_wr(8'h84, 32'hFFFF_FFFF);
      bus_rd(8'h84, 32'h1FE);
      bus_wr(8'h84, 32'h0);
      bus_wr(8'h1C, 32'h0);
      bus_wr(8'h00, 32'h5);
      bus_rd(8'h00, 0);
      bus_wr(8'h90, 32'hABCD);
      bus_rd(8'h90, 0);

      // level source 2
      bus_wr(8'h08, 32'd1);
      bus_wr(8'h84, 32'h04);
      bus_wr(8'h88, 32'd0);
      source_irq[2] = 1'b1;
      idle(2);
      bus_rd(8'h80, 0);
      bus_rd(8'h80, 32'h04);
      idle(1);
      bus_rd(8'h8C, 2);
      bus_rd(8'h80, 0);
      idle(3);
      bus_rd(8'h80, 0);
      bus_wr(8'h8C, 32'd2);
      bus_rd(8'h80, 0);
      bus_rd(8'h80, 32'h04);
      source_irq[2] = 1'b0;
      idle(4);
      bus_rd(8'h8C, 2);
      bus_wr(8'h8C, 32'd2);
      idle(3);
      bus_rd(8'h80, 0);

      // priority order 4, 5, 1
      bus_wr(8'h04, 32'd2);
      bus_wr(8'h10, 32'd5);
      bus_wr(8'h14, 32'd5);
      bus_wr(8'h84, 32'h36);
      source_irq[1] = 1'b1;
      source_irq[4] = 1'b1;
      source_irq[5] = 1'b1;
      idle(4);
      bus_rd(8'h80, 32'h32);
      bus_rd(8'h8C, 4);
      bus_rd(8'h8C, 5);
      bus_rd(8'h8C, 1);
      bus_rd(8'h8C, 0);
      source_irq[1] = 1'b0;
      source_irq[4] = 1'b0;
      source_irq[5] = 1'b0;
      idle(4);
      bus_wr(8'h8C, 32'd4);
      bus_wr(8'h8C, 32'd5);
      bus_wr(8'h8C, 32'd1);
      idle(3);
      bus_rd(8'h80, 0);

      // threshold gating
      bus_wr(8'h88, 32'd5);
      source_irq[4] = 1'b1;
      idle(5);
      check("thr_blocked", {31'b0, external_interrupt}, 32'h0);
      bus_rd(8'h80, 32'h10);
      bus_wr(8'h88, 32'd4);
      check("thr_same_edge", {31'b0, external_interrupt}, 32'h0);
      tick();
      check("thr_next_edge", {31'b0, external_interrupt}, 32'h1);
      bus_rd(8'h8C, 4);
      source_irq[4] = 1'b0;
      idle(4);
      bus_wr(8'h8C, 32'd4);
      bus_wr(8'h88, 32'd0);

      // edge source 6
      bus_wr(8'h18, 32'd3);
      bus_wr(8'h84, 32'h76);
      source_irq[6] = 1'b1;
      tick();
      source_irq[6] = 1'b0;
      idle(4);
      bus_rd(8'h8C, 6);
      bus_rd(8'h80, 0);
      source_irq[6] = 1'b1;
      tick();
      source_irq[6] = 1'b0;
      idle(4);
      bus_rd(8'h80, 32'h40);
      source_irq[6] = 1'b1;
      tick();
      source_irq[6] = 1'b0;
      tick();
      bus_rd(8'h8C, 6);
      bus_rd(8'h80, 32'h40);
      bus_rd(8'h8C, 6);
      bus_rd(8'h80, 0);
      bus_wr(8'h8C, 32'd6);
      bus_wr(8'h8C, 32'd6);
      idle(2);

      // ignored completes, then claim and complete in one cycle
      source_irq[2] = 1'b1;
      idle(4);
      bus_rd(8'h8C, 2);
      bus_wr(8'h8C, 32'd0);
      bus_wr(8'h8C, 32'd9);
      bus_wr(8'h8C, 32'd3);
      idle(2);
      bus_rd(8'h80, 0);
      bus_wr(8'h8C, 32'd2);
      bus_rd(8'h80, 0);
      bus_rd(8'h80, 32'h04);
      source_irq[4] = 1'b1;
      idle(4);
      bus_rd(8'h8C, 4);
      bus_rdwr(8'h8C, 32'd4, 2);
      bus_rd(8'h80, 0);
      bus_rd(8'h80, 32'h10);
      source_irq[2] = 1'b0;
      source_irq[4] = 1'b0;
      idle(4);
      bus_rd(8'h8C, 4);
      bus_wr(8'h8C, 32'd4);
      bus_wr(8'h8C, 32'd2);
      idle(3);
      bus_rd(8'h80, 0);

      // asynchronous reset with source 3 pending
      bus_wr(8'h0C, 32'd1);
      bus_wr(8'h84, 32'h7E);
      source_irq[3] = 1'b1;
      idle(4);
      bus_rd(8'h80, 32'h08);
      idle(1);
      check("pre_reset_ext", {31'b0, external_interrupt}, 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rdata", bus_read_data, 32'h0);
      check("async_valid", {31'b0, bus_read_valid}, 32'h0);
      check("async_ext", {31'b0, external_interrupt}, 32'h0);
      source_irq[3] = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;
      bus_rd(8'h80, 0);
      bus_rd(8'h8C, 0);
      bus_rd(8'h84, 0);
      bus_rd(8'h0C, 0);

      // randomised phase
      for (int i = 1; i <= N; i++) bus_wr(8'(i * 4), 32'($urandom_range(0, 7)));
      bus_wr(8'h84, 32'h1FE);
      bus_wr(8'h88, 32'($urandom_range(0, 3)));
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            s = int'($urandom_range(1, N));
            source_irq[s] = ~source_irq[s];
         end
         op = int'($urandom_range(0, 9));
         case (op)
            4, 5:    bus_rd(8'h8C, -1);
            6:       bus_wr(8'h8C, 32'($urandom_range(0, 10)));
            7:       bus_rd(rand_addr(), -1);
            8:       bus_wr(rand_addr(), $urandom);
            9:       bus_rdwr(8'h8C, 32'($urandom_range(0, 10)), -1);
            default: tick();
         endcase
      end
      idle(4);
      check("queue_drain", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
